// File: rtl/iobuf_vec_ctrl.sv
// iobuf_vec_ctrl
// Transaction sequencer for a shared bidirectional pad bus built from an
// IOBUF vector stage. It owns the IOBUF I/T controls and consumes the
// pad-side O return. Write and read requests arrive on a valid/ready channel
// and become timed windows:
//   - a write drives the bus, then releases it for a turnaround period;
//   - a read waits with the bus released, then captures the synchronized bus.
// Read data is returned on a response channel that holds until it is taken.
//
// Ports:
//   CLK        single clock, all state updates on the rising edge
//   RST        asynchronous active-high reset
//   req_valid  request present
//   req_ready  request accepted when req_valid && req_ready at a CLK edge
//   req_write  1 = write, 0 = read
//   req_data   write data
//   rsp_valid  read data available
//   rsp_ready  consumer takes the response
//   rsp_data   read data
//   pin_I      IOBUF I (value driven onto the pads)
//   pin_T      IOBUF T, 1 = released (high-Z), 0 = driving
//   pin_O      IOBUF O, asynchronous to CLK
module iobuf_vec_ctrl #(
  parameter int IOVEC_WIDTH  = 8,
  parameter int DRIVE_CYCLES = 2,
  parameter int TURN_CYCLES  = 1,
  parameter int READ_WAIT    = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [IOVEC_WIDTH-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IOVEC_WIDTH-1:0] rsp_data,
  output logic [IOVEC_WIDTH-1:0] pin_I,
  output logic                   pin_T,
  input  logic [IOVEC_WIDTH-1:0] pin_O
);

  localparam int MAX_A  = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int MAX_C  = (MAX_A > READ_WAIT) ? MAX_A : READ_WAIT;
  localparam int CNT_W  = (MAX_C > 0) ? $clog2(MAX_C + 1) : 1;

  // Terminal counts for each timed window; the counter starts at 0 on entry
  // to a state, so the window ends on the edge where it equals N-1.
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DRIVE,
    TURN,
    RD_WAIT,
    RSP
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic                   r_reqReady;
  logic                   r_rspValid;
  logic [IOVEC_WIDTH-1:0] r_rspData;
  logic [IOVEC_WIDTH-1:0] r_pinI;
  logic                   r_pinT;
  logic [IOVEC_WIDTH-1:0] r_sync1;
  logic [IOVEC_WIDTH-1:0] r_sync2;
  logic                   w_accept;

  assign w_accept  = req_valid && r_reqReady;

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;
  assign pin_I     = r_pinI;
  assign pin_T     = r_pinT;

  // Two-flop synchronizer for the pad return; it runs every cycle so the
  // captured sample always reflects a settled bus value.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_O;
      r_sync2 <= r_sync1;
    end
  end

  // Sequencer. Every output is a register so the IOBUF controls never see
  // combinational hazards. pin_T is cleared only on entry to WR_DRIVE and set
  // on the edge leaving it, so back-to-back transactions cannot glitch it.
  // req_ready is set in IDLE when it is low (after reset or after a response
  // handshake), and set directly on the edge ending a write so the next
  // request can follow the turnaround without an extra idle cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= '0;
      r_pinI     <= '0;
      r_pinT     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_accept) begin
            r_reqReady <= 1'b0;
            if (req_write) begin
              r_state <= WR_DRIVE;
              r_pinI  <= req_data;
              r_pinT  <= 1'b0;
            end else begin
              r_state <= RD_WAIT;
            end
          end else begin
            r_reqReady <= 1'b1;
          end
        end

        WR_DRIVE: begin
          if (r_count == DRIVE_LAST) begin
            r_pinT  <= 1'b1;
            r_count <= '0;
            if (TURN_CYCLES > 0) begin
              r_state <= TURN;
            end else begin
              r_state    <= IDLE;
              r_reqReady <= 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        TURN: begin
          if (r_count == TURN_LAST) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_reqReady <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        RD_WAIT: begin
          if (r_count == READ_LAST) begin
            r_state    <= RSP;
            r_count    <= '0;
            r_rspData  <= r_sync2;
            r_rspValid <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_count    <= '0;
          r_reqReady <= 1'b0;
          r_rspValid <= 1'b0;
          r_pinT     <= 1'b1;
        end
      endcase
    end
  end

endmodule
